// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI sprite receive path.
// Imported by the synchroniser and the receiver top level.
package spi_pkg;

    localparam int         SPI_BYTE_W   = 8;
    localparam int         RECORD_BYTES = 6;
    localparam logic [7:0] CMD_SPRITE   = 8'h01;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_PAYLOAD,
        ST_DISCARD,
        ST_FLUSH
    } spi_rx_state_t;

endpackage

// File: rtl/spi_input_sync.sv
// Multi-stage synchroniser for an asynchronous SPI line.
// Adds registered rise/fall pulses and a configurable reset level.
module spi_input_sync
    import spi_pkg::*;
#(
    parameter int   STAGES    = 2,
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clock,
    input  logic reset_n,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] sync_q;
    logic              prev_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= {STAGES{RESET_VAL}};
            prev_q <= RESET_VAL;
            rise   <= 1'b0;
            fall   <= 1'b0;
        end else begin
            sync_q[0] <= din;
            for (int i = 1; i < STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
            prev_q <= sync_q[STAGES-1];
            rise   <= sync_q[STAGES-1] & ~prev_q;
            fall   <= ~sync_q[STAGES-1] & prev_q;
        end
    end

    assign level = sync_q[STAGES-1];

endmodule

// File: rtl/spi_sprite_receiver.sv
// SPI-slave front end: deserialises MSB-first bytes, decodes the command
// header and forwards sprite payload bytes to the sprite queue.
module spi_sprite_receiver
    import spi_pkg::*;
#(
    parameter int         SYNC_STAGES  = 2,
    parameter int         RECORD_BYTES = spi_pkg::RECORD_BYTES,
    parameter logic [7:0] CMD_SPRITE   = spi_pkg::CMD_SPRITE
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  spi_sck,
    input  logic                  spi_mosi,
    input  logic                  spi_cs_n,
    output logic                  data_clk,
    output logic                  enqueue_en,
    output logic [SPI_BYTE_W-1:0] enqueue_data,
    output logic                  frame_error,
    output logic [7:0]            record_count
);

    localparam int IDX_W = (RECORD_BYTES > 1) ? $clog2(RECORD_BYTES) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(RECORD_BYTES - 1);

    logic sck_lvl;
    logic sck_rise;
    logic sck_fall;
    logic cs_lvl;
    logic cs_rise;
    logic cs_fall;
    logic unused_sync;

    // Synchronisers reset to 0 so a CS held low across reset is no frame start
    spi_input_sync #(
        .STAGES    (SYNC_STAGES),
        .RESET_VAL (1'b0)
    ) u_sck_sync (
        .clock   (clock),
        .reset_n (reset_n),
        .din     (spi_sck),
        .level   (sck_lvl),
        .rise    (sck_rise),
        .fall    (sck_fall)
    );

    spi_input_sync #(
        .STAGES    (SYNC_STAGES),
        .RESET_VAL (1'b0)
    ) u_cs_sync (
        .clock   (clock),
        .reset_n (reset_n),
        .din     (spi_cs_n),
        .level   (cs_lvl),
        .rise    (cs_rise),
        .fall    (cs_fall)
    );

    assign unused_sync = ^{sck_lvl, sck_fall, cs_lvl};

    logic [SYNC_STAGES-1:0] mosi_q;
    logic                   mosi_s;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            mosi_q <= '0;
        end else begin
            mosi_q[0] <= spi_mosi;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                mosi_q[i] <= mosi_q[i-1];
            end
        end
    end

    assign mosi_s = mosi_q[SYNC_STAGES-1];

    spi_rx_state_t         state_q;
    spi_rx_state_t         state_n;
    logic [SPI_BYTE_W-1:0] shift_q;
    logic [SPI_BYTE_W-1:0] next_byte;
    logic [2:0]            bit_cnt_q;
    logic [IDX_W-1:0]      rec_idx_q;
    logic                  pend_q;
    logic                  pend_n;
    logic                  byte_done;
    logic                  capture;
    logic                  start;
    logic                  push;
    logic                  flush;
    logic                  err_set;

    assign next_byte = {shift_q[SPI_BYTE_W-2:0], mosi_s};
    assign byte_done = sck_rise && (bit_cnt_q == 3'd7);
    assign capture   = sck_rise &&
                       (state_q inside {ST_CMD, ST_PAYLOAD, ST_DISCARD});

    always_comb begin
        state_n = state_q;
        pend_n  = pend_q;
        start   = 1'b0;
        push    = 1'b0;
        flush   = 1'b0;
        err_set = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (cs_fall || pend_q) begin
                    state_n = ST_CMD;
                    pend_n  = 1'b0;
                    start   = 1'b1;
                end
            end
            ST_CMD: begin
                if (cs_rise) begin
                    state_n = ST_IDLE;
                    err_set = (bit_cnt_q != 3'd0);
                end else if (byte_done) begin
                    state_n = (next_byte == CMD_SPRITE) ? ST_PAYLOAD
                                                        : ST_DISCARD;
                end
            end
            ST_PAYLOAD: begin
                if (cs_rise) begin
                    err_set = (bit_cnt_q != 3'd0);
                    if (rec_idx_q != '0) begin
                        state_n = ST_FLUSH;
                        flush   = 1'b1;
                        err_set = 1'b1;
                    end else begin
                        state_n = ST_IDLE;
                    end
                end else if (byte_done) begin
                    push = 1'b1;
                end
            end
            ST_DISCARD: begin
                if (cs_rise) begin
                    state_n = ST_IDLE;
                    err_set = (bit_cnt_q != 3'd0);
                end
            end
            ST_FLUSH: begin
                state_n = ST_IDLE;
                if (cs_fall) begin
                    pend_n = 1'b1;
                end
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            pend_q  <= 1'b0;
        end else begin
            state_q <= state_n;
            pend_q  <= pend_n;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            shift_q      <= '0;
            bit_cnt_q    <= '0;
            rec_idx_q    <= '0;
            record_count <= '0;
            frame_error  <= 1'b0;
        end else if (start) begin
            bit_cnt_q    <= '0;
            rec_idx_q    <= '0;
            record_count <= '0;
            frame_error  <= 1'b0;
        end else begin
            if (capture) begin
                shift_q   <= next_byte;
                bit_cnt_q <= bit_cnt_q + 3'd1;
            end
            if (push) begin
                if (rec_idx_q == IDX_LAST) begin
                    rec_idx_q <= '0;
                    if (record_count != 8'hFF) begin
                        record_count <= record_count + 8'd1;
                    end
                end else begin
                    rec_idx_q <= rec_idx_q + IDX_W'(1);
                end
            end
            if (err_set) begin
                frame_error <= 1'b1;
            end
        end
    end

    // A flush strobe keeps the last byte on the bus and only drops enqueue_en
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            data_clk     <= 1'b0;
            enqueue_en   <= 1'b0;
            enqueue_data <= '0;
        end else begin
            data_clk <= push | flush;
            if (push) begin
                enqueue_en   <= 1'b1;
                enqueue_data <= next_byte;
            end else if (flush) begin
                enqueue_en <= 1'b0;
            end
        end
    end

endmodule
